// File: rtl/bamse_irq_ctrl.sv
// 8-source prioritised interrupt controller on a PacoBlaze port window (PENDING/MASK/VECTOR/EDGE_SEL).
// Define BAMSE_IRQ_SYNC_EN to put a 2-flop synchronizer ahead of the s1 sample stage.
module bamse_irq_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'hE0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_src,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] s1_q, s2_q;
  logic [7:0] s1_in;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] esel_q, esel_d;
  logic [2:0] vid_q, vid_d;
  logic       vvld_q, vvld_d;

  logic       hit;
  logic       wr_pend, wr_mask, wr_vec, wr_esel;
  logic [7:0] edge_det, w1c, ack_clr, active;
  logic [2:0] pick;
  logic       unused_rd;

  // Reads are purely combinational, so the strobe carries no information here.
  assign unused_rd = read_strobe;

`ifdef BAMSE_IRQ_SYNC_EN
  logic [7:0] sy0_q, sy1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sy0_q <= '0;
      sy1_q <= '0;
    end else begin
      sy0_q <= irq_src;
      sy1_q <= sy0_q;
    end
  end

  assign s1_in = sy1_q;
`else
  assign s1_in = irq_src;
`endif

  assign hit     = (port_id[7:2] == BASE_ADDR[7:2]);
  assign wr_pend = write_strobe && hit && (port_id[1:0] == 2'd0);
  assign wr_mask = write_strobe && hit && (port_id[1:0] == 2'd1);
  assign wr_vec  = write_strobe && hit && (port_id[1:0] == 2'd2);
  assign wr_esel = write_strobe && hit && (port_id[1:0] == 2'd3);

  assign edge_det = s1_q & ~s2_q;
  assign w1c      = wr_pend ? out_port : 8'h00;
  assign active   = pend_q & mask_q;
  assign mask_d   = wr_mask ? out_port : mask_q;
  assign esel_d   = wr_esel ? out_port : esel_q;

  // Edge bits: a new edge beats any clear in the same cycle. Level bits track s1.
  assign pend_d = (esel_q & (edge_det | (pend_q & ~w1c & ~ack_clr)))
                | (~esel_q & s1_q);

  always_comb begin
    pick = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) pick = i[2:0];
    end
  end

  always_comb begin
    state_d = state_q;
    vid_d   = vid_q;
    vvld_d  = vvld_q;
    ack_clr = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (|active) begin
          state_d = S_ASSERT;
          vid_d   = pick;
          vvld_d  = 1'b1;
        end
      end
      S_ASSERT: begin
        if (interrupt_ack) begin
          state_d        = S_SERVICE;
          ack_clr[vid_q] = esel_q[vid_q];
        end
      end
      S_SERVICE: begin
        if (wr_vec) begin
          state_d = S_IDLE;
          vvld_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign interrupt = (state_q == S_ASSERT);

  always_comb begin
    in_port = 8'h00;
    if (hit) begin
      case (port_id[1:0])
        2'd0:    in_port = pend_q;
        2'd1:    in_port = mask_q;
        2'd2:    in_port = {vvld_q, 4'b0000, vid_q};
        default: in_port = esel_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      pend_q  <= '0;
      mask_q  <= 8'h00;
      esel_q  <= 8'hFF;
      vid_q   <= 3'd0;
      vvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_in;
      s2_q    <= s1_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      esel_q  <= esel_d;
      vid_q   <= vid_d;
      vvld_q  <= vvld_d;
    end
  end

endmodule

// File: tb/tb_bamse_irq_ctrl.sv
// Directed bench for bamse_irq_ctrl: register-window vector table plus hand-built interrupt sequences.
module tb_bamse_irq_ctrl;

`ifdef BAMSE_IRQ_SYNC_EN
  localparam int X = 2;
`else
  localparam int X = 0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] irq_src;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  int checks;
  int errors;

  bamse_irq_ctrl #(.BASE_ADDR(8'hE0)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_src      (irq_src),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_wr;
    logic [7:0] waddr;
    logic [7:0] wdat;
    logic [7:0] raddr;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id      = a;
    out_port     = d;
    write_strobe = 1'b1;
    tick(1);
    write_strobe = 1'b0;
    port_id      = 8'h00;
    out_port     = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    port_id     = a;
    read_strobe = 1'b1;
    #1;
    check(nm, in_port, exp);
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  task automatic chk_int(input logic exp, input string nm);
    check(nm, {7'b0, interrupt}, {7'b0, exp});
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    irq_src       = 8'h00;
    port_id       = 8'h00;
    write_strobe  = 1'b0;
    read_strobe   = 1'b0;
    out_port      = 8'h00;
    interrupt_ack = 1'b0;

    tbl[0]  = '{1'b0, 8'h00, 8'h00, 8'hE0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 8'h00, 8'hE1, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 8'h00, 8'hE2, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 8'hE3, 8'hFF};
    tbl[4]  = '{1'b1, 8'hE1, 8'hA5, 8'hE1, 8'hA5};
    tbl[5]  = '{1'b1, 8'hE3, 8'h5A, 8'hE3, 8'h5A};
    tbl[6]  = '{1'b0, 8'h00, 8'h00, 8'hE4, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 8'h00, 8'hDF, 8'h00};
    tbl[8]  = '{1'b1, 8'hE5, 8'h3C, 8'hE1, 8'hA5};
    tbl[9]  = '{1'b1, 8'hE2, 8'h00, 8'hE2, 8'h00};
    tbl[10] = '{1'b1, 8'hE1, 8'h00, 8'hE1, 8'h00};
    tbl[11] = '{1'b1, 8'hE3, 8'hFF, 8'hE3, 8'hFF};
    tbl[12] = '{1'b1, 8'hE0, 8'hFF, 8'hE0, 8'h00};

    #3;
    check("rst_async_int", {7'b0, interrupt}, 8'h00);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk_int(1'b0, "rst_int");

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].do_wr) wr(tbl[i].waddr, tbl[i].wdat);
      else tick(1);
      rd(tbl[i].raddr, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // single edge pulse on source 0: latency, vector, ack, EOI, stray ack
    wr(8'hE1, 8'h01);
    irq_src = 8'h01;
    tick(1);
    irq_src = 8'h00;
    tick(X);
    chk_int(1'b0, "A_int_e1");
    tick(1);
    rd(8'hE0, 8'h01, "A_pend_e2");
    chk_int(1'b0, "A_int_e2");
    tick(1);
    chk_int(1'b1, "A_int_e3");
    rd(8'hE2, 8'h80, "A_vec");
    ack();
    chk_int(1'b0, "A_int_ack");
    rd(8'hE0, 8'h00, "A_pend_ack");
    rd(8'hE2, 8'h80, "A_vec_svc");
    wr(8'hE2, 8'h00);
    rd(8'hE2, 8'h00, "A_vec_eoi");
    tick(1);
    chk_int(1'b0, "A_int_idle");
    ack();
    chk_int(1'b0, "A_stray_ack");
    rd(8'hE2, 8'h00, "A_vec_stray");

    // simultaneous sources 5 and 2: priority then back-to-back service
    wr(8'hE1, 8'hFF);
    irq_src = 8'h24;
    tick(2 + X);
    chk_int(1'b0, "B_int_e2");
    tick(1);
    chk_int(1'b1, "B_int_e3");
    rd(8'hE2, 8'h82, "B_vec2");
    irq_src = 8'h00;
    ack();
    chk_int(1'b0, "B_int_ack");
    rd(8'hE0, 8'h20, "B_pend_left");
    wr(8'hE2, 8'h00);
    chk_int(1'b0, "B_gap");
    tick(1);
    chk_int(1'b1, "B_rearb");
    rd(8'hE2, 8'h85, "B_vec5");
    ack();
    wr(8'hE2, 8'h00);
    rd(8'hE0, 8'h00, "B_pend_empty");
    tick(2);
    chk_int(1'b0, "B_quiet");

    // level source 0 held high: W1C ignored, re-assert after each EOI
    reset_dut();
    wr(8'hE3, 8'hFE);
    wr(8'hE1, 8'h01);
    irq_src = 8'h01;
    for (int i = 0; i < 12 && !interrupt; i++) tick(1);
    chk_int(1'b1, "C_int");
    rd(8'hE2, 8'h80, "C_vec");
    wr(8'hE0, 8'h01);
    rd(8'hE0, 8'h01, "C_w1c_ignored");
    ack();
    chk_int(1'b0, "C_int_ack");
    rd(8'hE0, 8'h01, "C_pend_ack");
    for (int k = 0; k < 2; k++) begin
      wr(8'hE2, 8'h00);
      chk_int(1'b0, $sformatf("C_eoi%0d", k));
      tick(1);
      chk_int(1'b1, $sformatf("C_rearm%0d", k));
      ack();
    end
    irq_src = 8'h00;
    tick(3 + X);
    wr(8'hE2, 8'h00);
    tick(3);
    chk_int(1'b0, "C_quiet");
    rd(8'hE0, 8'h00, "C_pend_low");

    // edge bit 3: W1C in the same cycle as a new edge keeps it pending
    reset_dut();
    irq_src = 8'h08;
    tick(1);
    irq_src = 8'h00;
    tick(1 + X);
    rd(8'hE0, 8'h08, "D_pend");
    irq_src = 8'h08;
    tick(1);
    irq_src = 8'h00;
    tick(X);
    wr(8'hE0, 8'h08);
    rd(8'hE0, 8'h08, "D_set_wins");
    wr(8'hE0, 8'h08);
    rd(8'hE0, 8'h00, "D_w1c");

    // masked request pends silently, unmask raises interrupt
    irq_src = 8'h10;
    tick(1);
    irq_src = 8'h00;
    tick(2 + X);
    rd(8'hE0, 8'h10, "E_pend");
    chk_int(1'b0, "E_masked");
    wr(8'hE1, 8'hFF);
    chk_int(1'b0, "E_int_w1");
    tick(1);
    chk_int(1'b1, "E_int_w2");
    rd(8'hE2, 8'h84, "E_vec");
    ack();
    chk_int(1'b0, "E_svc");

    // reset in SERVICE: immediate, no clock edge needed
    #2;
    rst = 1'b0;
    #1;
    chk_int(1'b0, "F_int");
    rd(8'hE1, 8'h00, "F_mask");
    rd(8'hE3, 8'hFF, "F_esel");
    rd(8'hE0, 8'h00, "F_pend");
    rd(8'hE2, 8'h00, "F_vec");
    rd(8'h10, 8'h00, "F_outside");
    rst = 1'b1;
    tick(3);
    chk_int(1'b0, "F_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
